// File: rtl/ram_pkg.sv
// Shared types and default sizes for the clearable synchronous RAM.
package ram_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 16;

  typedef enum logic [0:0] {
    IDLE,
    CLEARING
  } clr_state_e;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address once, issuing a zero write per cycle while busy.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e      state_q, state_d;
  // One extra bit so the sweep end shows up as a carry out, not a wrap to zero.
  logic [ADDR_W:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        // A reset edge aborts the sweep without zeroing the current word.
        clr_we = ~reset;
        cnt_d  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        if (cnt_d[ADDR_W]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEARING);
  assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with registered read and a whole-array clear sequence.
// Define RAM_WRFWD_EN for write-first read-during-write; default is read-first.
module sync_ram_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              valid,
  output logic              busy
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              start_clr, wr_acc, rd_acc;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dataout_q;
  logic              valid_q;

  ram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // A clear request in the same cycle wins over any access.
  assign start_clr = clear & ~busy;
  assign wr_acc    = we & ~busy & ~clear & ~reset;
  assign rd_acc    = re & ~busy & ~clear & ~reset;

`ifdef RAM_WRFWD_EN
  assign rd_data = wr_acc ? datain : mem[address];
`else
  assign rd_data = mem[address];
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[address] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q <= '0;
      valid_q   <= 1'b0;
    end else if (rd_acc) begin
      dataout_q <= rd_data;
      valid_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (start_clr) begin
        dataout_q <= '0;
      end
    end
  end

  assign dataout = dataout_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Directed bench for sync_ram_clr at ADDR_W=4, DATA_W=8; honours RAM_WRFWD_EN for expectations.
module tb_sync_ram_clr;

  logic       clk = 1'b0;
  logic       reset, clear, we, re;
  logic [3:0] address;
  logic [7:0] datain, dataout;
  logic       valid, busy;

  int n_cmp = 0;
  int n_bad = 0;

  sync_ram_clr #(
    .DATA_W(8),
    .ADDR_W(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .we     (we),
    .re     (re),
    .address(address),
    .datain (datain),
    .dataout(dataout),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] edout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    reset = 1'b0; clear = 1'b0; we = 1'b0; re = 1'b0;
    address = '0; datain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; address = a; datain = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [3:0] a, input logic [7:0] exp);
    re = 1'b1; address = a;
    tick();
    re = 1'b0;
    chk({name, " valid"}, 32'(valid), 32'd1);
    chk({name, " data"}, 32'(dataout), 32'(exp));
  endtask

  task automatic fill(input logic [7:0] d);
    for (int i = 0; i < 16; i++) do_write(4'(i), d);
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] rdw_exp;

`ifdef RAM_WRFWD_EN
    rdw_exp = 8'h22;
`else
    rdw_exp = 8'h11;
`endif

    vecs[0] = '{1'b1, 1'b0, 4'h3, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'h3, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 4'h3, 8'h00, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 4'h2, 8'h11, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 4'h2, 8'h22, 1'b1, rdw_exp};
    vecs[5] = '{1'b0, 1'b1, 4'h2, 8'h00, 1'b1, 8'h22};
    vecs[6] = '{1'b1, 1'b0, 4'h9, 8'h5A, 1'b0, 8'h22};
    vecs[7] = '{1'b0, 1'b1, 4'h9, 8'h00, 1'b1, 8'h5A};
    vecs[8] = '{1'b0, 1'b1, 4'h3, 8'h00, 1'b1, 8'hA5};
    vecs[9] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'hA5};

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset dataout", 32'(dataout), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);

    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; re = vecs[i].re; address = vecs[i].a; datain = vecs[i].d;
      tick();
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d data", i), 32'(dataout), 32'(vecs[i].edout));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
    end
    idle_in();

    // Full clear, colliding with a write and read in the start cycle.
    fill(8'hFF);
    clear = 1'b1; we = 1'b1; re = 1'b1; address = 4'h7; datain = 8'h3C;
    tick();
    chk("clr start valid", 32'(valid), 32'h0);
    chk("clr start data", 32'(dataout), 32'h0);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      busy_cnt++;
      // Accesses and a second clear while busy must all be ignored.
      clear = 1'b1; we = 1'b1; re = 1'b1; address = 4'h5; datain = 8'h77;
      tick();
      if (valid !== 1'b0 || dataout !== 8'h00)
        chk($sformatf("busy cyc%0d out", c), {valid, dataout}, 32'h0);
    end
    idle_in();
    chk("clear busy cycles", 32'(busy_cnt), 32'd16);
    for (int i = 0; i < 16; i++) do_read($sformatf("after clr %0h", i), 4'(i), 8'h00);

    // Reset aborts a clear after five sweep cycles.
    fill(8'hFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort valid", 32'(valid), 32'h0);
    chk("abort data", 32'(dataout), 32'h0);
    for (int i = 0; i < 16; i++)
      do_read($sformatf("abort rd %0h", i), 4'(i), (i < 5) ? 8'h00 : 8'hFF);

    // Reset beats a simultaneous write and read.
    reset = 1'b1; we = 1'b1; re = 1'b1; address = 4'h1; datain = 8'h99;
    tick();
    idle_in();
    chk("rst vs rd valid", 32'(valid), 32'h0);
    do_read("rst vs wr", 4'h1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
